// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the req/gnt/rvalid data memory port.
//   Accepts one load/store from the execute stage, generates byte enables,
//   lane-replicated write data and a word-aligned address, and returns
//   sign/zero-extended load data or store completion with a one-cycle lsu_done.
// Ports:
//   clk, reset_n (async, active-low)
//   core side: lsu_valid/lsu_ready handshake, lsu_we, lsu_fun3, lsu_addr, lsu_wdata;
//              lsu_done pulse with lsu_rdata and lsu_err
//   memory side: mem_req/mem_gnt, mem_we, mem_be, mem_addr, mem_wdata; mem_rvalid/mem_rdata
// Parameters: WIDTH (32 only), TIMEOUT (max WAIT_RESP cycles, 0 disables)
// Configuration: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses;
//   otherwise they are forced down to natural alignment.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic             lsu_we,
  input  logic [2:0]       lsu_fun3,
  input  logic [WIDTH-1:0] lsu_addr,
  input  logic [WIDTH-1:0] lsu_wdata,
  output logic             lsu_done,
  output logic [WIDTH-1:0] lsu_rdata,
  output logic             lsu_err,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;
  state_t state, state_next;
  logic [2:0]       fun3_q;
  logic [1:0]       off_q;
  logic [15:0]      cnt;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic             accept, legal, fault, timeout;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [WIDTH-1:0] rep, shifted, ext;

  assign accept = state == IDLE && lsu_valid;
  assign legal  = lsu_we ? (lsu_fun3 == 3'b000 || lsu_fun3 == 3'b001 || lsu_fun3 == 3'b010)
                         : !(lsu_fun3 == 3'b011 || lsu_fun3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (lsu_fun3[1:0] == 2'b01 && lsu_addr[0]) ||
                    (lsu_fun3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00);
  assign fault = !legal || misalign;
`else
  assign fault = !legal;
`endif

  // Byte offset after forcing natural alignment (only matters when not trapping)
  assign off = lsu_fun3[1] ? 2'b00 : lsu_fun3[0] ? {lsu_addr[1], 1'b0} : lsu_addr[1:0];
  assign be  = lsu_fun3[1] ? 4'b1111 : lsu_fun3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
  assign rep = lsu_fun3[1] ? lsu_wdata : lsu_fun3[0] ? {2{lsu_wdata[15:0]}} : {4{lsu_wdata[7:0]}};

  // fun3[2] set means unsigned (LBU/LHU): suppress sign extension
  assign shifted = mem_rdata >> {off_q, 3'b000};
  assign ext = fun3_q[1] ? mem_rdata
             : fun3_q[0] ? {{16{!fun3_q[2] && shifted[15]}}, shifted[15:0]}
                         : {{24{!fun3_q[2] && shifted[7]}}, shifted[7:0]};

  // Fires in the cycle the counter would reach TIMEOUT; rvalid in that cycle still wins
  assign timeout = TIMEOUT != 0 && 32'(cnt) + 32'd1 == 32'(TIMEOUT);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (lsu_valid) state_next = fault ? DONE : REQ;
      REQ:       if (mem_gnt) state_next = WAIT_RESP;
      WAIT_RESP: if (mem_rvalid || timeout) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign lsu_ready = state == IDLE;
  assign mem_req   = state == REQ;
  assign lsu_done  = state == DONE;
  assign lsu_rdata = lsu_done ? rdata_q : '0;
  assign lsu_err   = lsu_done && err_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt       <= '0;
      fun3_q    <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cnt <= state == WAIT_RESP ? cnt + 16'd1 : '0;
      if (accept) begin
        err_q   <= fault;
        rdata_q <= '0;
        fun3_q  <= lsu_fun3;
        off_q   <= off;
        if (!fault) begin
          mem_we    <= lsu_we;
          mem_be    <= be;
          mem_addr  <= {lsu_addr[WIDTH-1:2], 2'b00};
          mem_wdata <= rep;
        end
      end
      if (state == WAIT_RESP && mem_rvalid) begin
        rdata_q <= mem_we ? '0 : ext;
        err_q   <= 1'b0;
      end else if (state == WAIT_RESP && timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lsu_valid = 1'b0, lsu_we = 1'b0;
  logic [2:0]  lsu_fun3 = '0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_ready, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  int          tests = 0, fails = 0;
  logic [32:0] sb[$];

  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_fun3(lsu_fun3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"}, lsu_ready, 1);
    chk({tag, " done"}, lsu_done, 0);
    chk({tag, " err"}, lsu_err, 0);
    chk({tag, " rdata"}, lsu_rdata, 0);
    chk({tag, " mem_req"}, mem_req, 0);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_be"}, mem_be, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic chk_mem(input string tag, input logic we, input logic [3:0] ebe,
                         input logic [31:0] ea, input logic [31:0] ewd);
    chk({tag, " mem_req"}, mem_req, 1);
    chk({tag, " mem_we"}, mem_we, we);
    chk({tag, " mem_be"}, mem_be, ebe);
    chk({tag, " mem_addr"}, mem_addr, ea);
    chk({tag, " mem_wdata"}, mem_wdata, ewd);
    chk({tag, " ready"}, lsu_ready, 0);
  endtask

  // One transaction: gd = cycles gnt is withheld, rvd = empty WAIT_RESP cycles before
  // rvalid, rv = whether rvalid is ever given, flt = expected fault without memory traffic.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int gd, input int rvd, input logic rv, input logic flt,
                     input logic [3:0] ebe, input logic [31:0] ea, input logic [31:0] ewd,
                     input logic [31:0] erd, input logic eerr);
    logic [32:0] e;
    sb.push_back({eerr, erd});
    @(negedge clk);
    chk({tag, " ready"}, lsu_ready, 1);
    lsu_valid = 1'b1; lsu_we = we; lsu_fun3 = f3; lsu_addr = a; lsu_wdata = wd;
    @(negedge clk);
    lsu_valid = 1'b0; lsu_we = ~we; lsu_fun3 = 3'b111; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h5A5A_5A5A;
    if (!flt) begin
      for (int i = 0; i < gd; i++) begin
        chk_mem({tag, " hold"}, we, ebe, ea, ewd);
        lsu_valid = 1'b1;
        @(negedge clk);
      end
      lsu_valid = 1'b0;
      chk_mem(tag, we, ebe, ea, ewd);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      for (int i = 0; i < rvd; i++) begin
        chk({tag, " wait mem_req"}, mem_req, 0);
        chk({tag, " wait done"}, lsu_done, 0);
        @(negedge clk);
      end
      if (rv) begin
        mem_rvalid = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
    end else chk({tag, " no mem_req"}, mem_req, 0);
    chk({tag, " done"}, lsu_done, 1);
    if (sb.size() == 0) chk({tag, " scoreboard empty"}, 1, 0);
    else begin
      e = sb.pop_front();
      chk({tag, " rdata"}, lsu_rdata, e[31:0]);
      chk({tag, " err"}, lsu_err, e[32]);
    end
    @(negedge clk);
    chk({tag, " done pulse"}, lsu_done, 0);
  endtask

  initial begin
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post reset");

    txn("SB", 1, 3'b000, 32'h102, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 1, 0,
        4'b0100, 32'h100, 32'hA5A5_A5A5, 32'h0, 0);
    txn("LB", 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 1, 0,
        4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80, 0);
    txn("LBU", 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 1, 0,
        4'b1000, 32'h100, 32'h0, 32'h0000_0080, 0);
    txn("LB0", 0, 3'b000, 32'h100, 32'h0, 32'h80FF_1234, 0, 1, 1, 0,
        4'b0001, 32'h100, 32'h0, 32'h0000_0034, 0);
    txn("LH", 0, 3'b001, 32'h102, 32'h0, 32'h8001_ABCD, 0, 0, 1, 0,
        4'b1100, 32'h100, 32'h0, 32'hFFFF_8001, 0);
    txn("LHU", 0, 3'b101, 32'h102, 32'h0, 32'h8001_ABCD, 0, 0, 1, 0,
        4'b1100, 32'h100, 32'h0, 32'h0000_8001, 0);
    txn("LH0", 0, 3'b001, 32'h100, 32'h0, 32'h8001_ABCD, 0, 0, 1, 0,
        4'b0011, 32'h100, 32'h0, 32'hFFFF_ABCD, 0);
    txn("SH", 1, 3'b001, 32'h010, 32'h1234_BEEF, 32'h0, 0, 0, 1, 0,
        4'b0011, 32'h010, 32'hBEEF_BEEF, 32'h0, 0);
    txn("SW gnt hold", 1, 3'b010, 32'h200, 32'h1234_5678, 32'h0, 5, 2, 1, 0,
        4'b1111, 32'h200, 32'h1234_5678, 32'h0, 0);
    txn("LW", 0, 3'b010, 32'h204, 32'h0, 32'hCAFE_F00D, 0, 0, 1, 0,
        4'b1111, 32'h204, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn("LW mis", 0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 1, 1,
        4'b0000, 32'h0, 32'h0, 32'h0, 1);
    txn("SH mis", 1, 3'b001, 32'h011, 32'h0000_BEEF, 32'h0, 0, 0, 1, 1,
        4'b0000, 32'h0, 32'h0, 32'h0, 1);
`else
    txn("LW mis", 0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 1, 0,
        4'b1111, 32'h100, 32'h0, 32'h1122_3344, 0);
    txn("SH mis", 1, 3'b001, 32'h013, 32'h0000_BEEF, 32'h0, 0, 0, 1, 0,
        4'b1100, 32'h010, 32'hBEEF_BEEF, 32'h0, 0);
`endif
    txn("bad load", 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1, 1,
        4'b0000, 32'h0, 32'h0, 32'h0, 1);
    txn("bad load2", 0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0, 1, 1,
        4'b0000, 32'h0, 32'h0, 32'h0, 1);
    txn("bad store", 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1, 1,
        4'b0000, 32'h0, 32'h0, 32'h0, 1);
    txn("timeout", 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 4, 0, 0,
        4'b1111, 32'h300, 32'h0, 32'h0, 1);
    txn("rvalid at limit", 0, 3'b010, 32'h304, 32'h0, 32'h7777_0001, 0, 3, 1, 0,
        4'b1111, 32'h304, 32'h0, 32'h7777_0001, 0);

    // Reset while waiting for the response
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_fun3 = 3'b010; lsu_addr = 32'h400;
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("mid reset mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("mid reset in wait", mem_req, 0);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid reset");
    @(negedge clk);
    reset_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after reset done", lsu_done, 0);
      chk("after reset ready", lsu_ready, 1);
    end
    mem_rvalid = 1'b0;
    chk("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
